// File: rtl/result_tx_sequencer_pkg.sv
// Shared types for the result transmit sequencer.
// State encoding, byte count and byte-index type.
package result_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        DONE
    } state_t;

    localparam int NUM_BYTES = 4;
    localparam int TMR_W     = 16;

    typedef logic [1:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(NUM_BYTES - 1);

    function automatic logic [NUM_BYTES-1:0] byte_sel(
        input byte_idx_t idx
    );
        logic [NUM_BYTES-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/result_tx_sequencer_if.sv
// Handshake bundle between the sequencer, the byte
// handler and the UART transmitter.
interface result_tx_sequencer_if;

    logic result_valid;
    logic tx_busy;
    logic register_result32;
    logic send_b0;
    logic send_b1;
    logic send_b2;
    logic send_b3;
    logic tx_start;
    logic seq_busy;
    logic frame_done;
    logic ack_err;
    logic overrun;

    modport master (
        input  result_valid,
        input  tx_busy,
        output register_result32,
        output send_b0,
        output send_b1,
        output send_b2,
        output send_b3,
        output tx_start,
        output seq_busy,
        output frame_done,
        output ack_err,
        output overrun
    );

    modport slave (
        output result_valid,
        output tx_busy,
        input  register_result32,
        input  send_b0,
        input  send_b1,
        input  send_b2,
        input  send_b3,
        input  tx_start,
        input  seq_busy,
        input  frame_done,
        input  ack_err,
        input  overrun
    );

endinterface

// File: rtl/result_tx_sequencer_byte_gap_timer.sv
// Loadable down-counter shared by the inter-byte gap
// and the transmitter acknowledge timeout.
module byte_gap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Load wins over counting; counter parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // Last cycle of a loaded interval.
    assign expire = (cnt == W'(1));

endmodule

// File: rtl/result_tx_sequencer.sv
// Sequences a 32-bit result out as four UART bytes,
// LSB first, with optional idle gaps between bytes.
module result_tx_sequencer
    import result_tx_pkg::*;
#(
    parameter int BYTE_GAP    = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    result_tx_sequencer_if.master bus
);

    localparam logic [TMR_W-1:0] GAP_LD = TMR_W'(BYTE_GAP);
    localparam logic [TMR_W-1:0] ACK_LD = TMR_W'(ACK_TIMEOUT);
    localparam bit HAS_GAP = (BYTE_GAP > 0);

    state_t     state;
    state_t     state_nxt;
    byte_idx_t  idx;
    byte_idx_t  idx_nxt;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_exp;
    logic             byte_done;
    logic             ack_set;

    logic                 reg32_q;
    logic [NUM_BYTES-1:0] send_q;
    logic                 start_q;
    logic                 busy_q;
    logic                 fdone_q;
    logic                 ack_q;
    logic                 ovr_q;

    byte_gap_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_exp)
    );

    // State and byte index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next state, next index and timer loads.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmr_load  = 1'b0;
        tmr_val   = ACK_LD;
        byte_done = 1'b0;
        ack_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.result_valid) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                state_nxt = START;
                idx_nxt   = '0;
            end
            START: begin
                state_nxt = WAIT_ACK;
                tmr_load  = 1'b1;
                tmr_val   = ACK_LD;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmr_exp) begin
                    byte_done = 1'b1;
                    ack_set   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            GAP: begin
                if (tmr_exp) begin
                    state_nxt = START;
                    idx_nxt   = idx + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (byte_done) begin
            if (idx == LAST_IDX) begin
                state_nxt = DONE;
            end else if (HAS_GAP) begin
                state_nxt = GAP;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LD;
            end else begin
                state_nxt = START;
                idx_nxt   = idx + 1'b1;
            end
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg32_q <= 1'b0;
            send_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            reg32_q <= (state_nxt == LATCH);
            start_q <= (state_nxt == START);
            busy_q  <= (state_nxt != IDLE);
            fdone_q <= (state_nxt == DONE);
            if (state_nxt == START ||
                state_nxt == WAIT_ACK ||
                state_nxt == WAIT_DONE) begin
                send_q <= byte_sel(idx_nxt);
            end else begin
                send_q <= '0;
            end
            ack_q <= ack_q | ack_set;
            ovr_q <= ovr_q |
                     (bus.result_valid && state != IDLE);
        end
    end

    assign bus.register_result32 = reg32_q;
    assign bus.send_b0           = send_q[0];
    assign bus.send_b1           = send_q[1];
    assign bus.send_b2           = send_q[2];
    assign bus.send_b3           = send_q[3];
    assign bus.tx_start          = start_q;
    assign bus.seq_busy          = busy_q;
    assign bus.frame_done        = fdone_q;
    assign bus.ack_err           = ack_q;
    assign bus.overrun           = ovr_q;

endmodule

// File: doc/result_tx_sequencer.md
RESULT_TX_SEQUENCER -- requirements
Module: result_tx_sequencer

Interface
REQ-001 Parameter BYTE_GAP, default 16, idle cycles inserted between consecutive bytes; 0 SHALL mean no gap state.
REQ-002 Parameter ACK_TIMEOUT, default 8, maximum cycles to wait for tx_busy to rise after tx_start; legal range 1..255.
REQ-003 Port clk  input  1  system clock, all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high.
REQ-005 Port result_valid  input  1  one-cycle pulse: 32-bit result present on the byte handler's data input.
REQ-006 Port tx_busy  input  1  UART transmitter busy.
REQ-007 Port register_result32  output  1  one-cycle strobe to byte handler to capture the result.
REQ-008 Port send_b0, send_b1, send_b2, send_b3  output  1 each  byte select to byte handler; at most one high.
REQ-009 Port tx_start  output  1  one-cycle start pulse to UART transmitter.
REQ-010 Port seq_busy  output  1  high in every state except IDLE.
REQ-011 Port frame_done  output  1  one-cycle pulse after byte 3 completes.
REQ-012 Port ack_err  output  1  sticky: some byte timed out waiting for tx_busy.
REQ-013 Port overrun  output  1  sticky: result_valid arrived while seq_busy high.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 States: IDLE, LATCH, START, WAIT_ACK, WAIT_DONE, GAP, DONE.
REQ-016 IDLE: result_valid at cycle N -> LATCH; register_result32 high in cycle N+1 only.
REQ-017 LATCH -> START; byte index SHALL reset to 0.
REQ-018 START (cycle N+2 for byte 0): tx_start high exactly one cycle; send_b<idx> high from this cycle through the last WAIT_DONE cycle of that byte.
REQ-019 WAIT_ACK: tx_busy high -> WAIT_DONE; after ACK_TIMEOUT cycles without tx_busy -> set ack_err, treat byte as complete.
REQ-020 WAIT_DONE: tx_busy low -> GAP if BYTE_GAP>0 and idx<3, else next byte START if idx<3, else DONE.
REQ-021 tx_busy already high on the cycle after START SHALL count as acknowledge.
REQ-022 GAP: count exactly BYTE_GAP cycles with all send_b* low, then idx+1 -> START.
REQ-023 Byte order: b0, b1, b2, b3 (LSB first); index 2 bits, no wrap beyond 3.
REQ-024 DONE: frame_done high one cycle -> IDLE.
REQ-025 result_valid in any non-IDLE state (including DONE) SHALL be dropped and set overrun; running frame unaffected.
REQ-026 result_valid in the IDLE cycle immediately following DONE SHALL be accepted normally.
REQ-027 ack_err and overrun clear only on reset.

Reset
REQ-028 reset SHALL force IDLE, idx=0, counters=0, all outputs 0 at the next edge, overriding any other input.
REQ-029 Reset mid-frame SHALL abort immediately; no tx_start, frame_done or send_b* pulse in the reset cycle or after it until a new result_valid.

Structure
REQ-030 Package result_tx_pkg SHALL hold the state enum, NUM_BYTES=4 and the byte-index typedef.
REQ-031 One sub-module byte_gap_timer (load value, count-down, expire pulse) SHALL serve both the GAP and the WAIT_ACK timeout.

Verification
REQ-032 result_valid at cycle 10, UART model raising busy 1 cycle after start and holding it 20 cycles, BYTE_GAP=16 -> register_result32 at 11; tx_start at 12, 34+16, ...; send_b0..b3 in order; frame_done once; ack_err=0.
REQ-033 BYTE_GAP=0 -> tx_start for byte k+1 one cycle after tx_busy falls for byte k; no GAP cycles.
REQ-034 UART model never asserts busy, ACK_TIMEOUT=8 -> each byte advances 8 cycles after its tx_start; ack_err=1; frame_done still pulses.
REQ-035 Second result_valid during byte 2 -> overrun=1; frame bytes unchanged; no second register_result32.
REQ-036 reset during WAIT_DONE of byte 1 -> all outputs 0 next cycle; new result_valid afterwards restarts at send_b0.
REQ-037 result_valid in the IDLE cycle after frame_done -> accepted, overrun stays 0.
